gbcam_reg_bank: RTL

- Parametrised Game Boy cartridge-bus register bank for the camera mapper; successor to the single-slot camera register front-end.
- Decodes CPU reads and writes in the SRAM window (A000-BFFF) when the selected RAM bank equals the register bank ID.
- Writes to the low addresses update a configurable number of direct control registers; writes to all other addresses are queued in a FIFO and drained to the tile/BRAM writer through a request/done handshake.
- Serves register-0 reads (capture status) back onto the bus; clears register 0 when capture finishes.

---
 rtl/gbcam_reg_bank.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/gbcam_reg_bank.sv
// Camera-mapper register bank: direct control registers plus a queued BRAM write path.
// Optional macro GBCAM_REG_READBACK_EN enables readback of registers 1..N-1 and a FIFO status byte.
module gbcam_reg_bank #(
    parameter int                     NUM_DIRECT_REGS = 6,
    parameter logic [4:0]             REG_BANK_ID     = 5'h10,
    parameter int                     ADDR_BITS       = 7,
    parameter int                     BRAM_ADDR_W     = 10,
    parameter logic [BRAM_ADDR_W-1:0] BRAM_BASE       = 10'h200,
    parameter int                     FIFO_DEPTH      = 4,
    parameter int                     SYNC_STAGES     = 2
) (
    input  logic                         sys_clock,
    input  logic                         sys_resetn,
    input  logic [15:0]                  Cart_a,
    input  logic [7:0]                   Cart_d_in,
    input  logic                         Cart_nRD,
    input  logic                         Cart_nWR,
    input  logic                         Cart_nCS,
    input  logic [4:0]                   Ram_bank_id,
    input  logic                         Sig_CamCaptureFinish,
    output logic                         Reg_OutputValid,
    output logic [7:0]                   Reg_OutputData,
    output logic                         Bram_Req_Write,
    output logic [BRAM_ADDR_W-1:0]       Bram_Addr,
    output logic [7:0]                   Bram_Data,
    input  logic                         Bram_WriteRegDone,
    output logic [8*NUM_DIRECT_REGS-1:0] Reg_Flat,
    output logic                         Cam_Capture,
    output logic [$clog2(FIFO_DEPTH):0]  Fifo_Level,
    output logic                         Fifo_Overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int WW = (ADDR_BITS > BRAM_ADDR_W) ? ADDR_BITS : BRAM_ADDR_W;
    localparam logic [ADDR_BITS-1:0] NUM_A = ADDR_BITS'(NUM_DIRECT_REGS);

    typedef enum logic {S_IDLE, S_REQ} drain_state_t;

    logic [SYNC_STAGES-1:0] nwr_sync, ncs_sync, nrd_sync, cap_sync;
    logic nwr_prev, ncs_prev, cap_prev;

    logic [7:0] regs [NUM_DIRECT_REGS];
    logic [BRAM_ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]             fifo_data [FIFO_DEPTH];
    logic [LW-1:0]          wr_ptr, rd_ptr, fifo_level;
    drain_state_t           state;

    logic                   sel, wr_evt, rd_evt, ncs_rise, cap_rise, is_direct;
    logic                   push_req, push_ok, pop, full, empty;
    logic [ADDR_BITS-1:0]   reg_addr, ofs;
    logic [WW-1:0]          ofs_wide;
    logic [BRAM_ADDR_W-1:0] push_addr;
    logic [7:0]             rd_value;
    logic                   unused_addr;

    assign unused_addr = ^Cart_a;

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            nwr_sync <= '1;
            ncs_sync <= '1;
            nrd_sync <= '1;
            cap_sync <= '0;
            nwr_prev <= 1'b1;
            ncs_prev <= 1'b1;
            cap_prev <= 1'b0;
        end else begin
            nwr_sync <= {nwr_sync[SYNC_STAGES-2:0], Cart_nWR};
            ncs_sync <= {ncs_sync[SYNC_STAGES-2:0], Cart_nCS};
            nrd_sync <= {nrd_sync[SYNC_STAGES-2:0], Cart_nRD};
            cap_sync <= {cap_sync[SYNC_STAGES-2:0], Sig_CamCaptureFinish};
            nwr_prev <= nwr_sync[SYNC_STAGES-1];
            ncs_prev <= ncs_sync[SYNC_STAGES-1];
            cap_prev <= cap_sync[SYNC_STAGES-1];
        end
    end

    // Address and data come straight from the bus; the CPU holds them stable across the strobe.
    assign sel       = (Cart_a[15:13] == 3'b101) && !Cart_nCS && (Ram_bank_id == REG_BANK_ID);
    assign reg_addr  = Cart_a[ADDR_BITS-1:0];
    assign wr_evt    = nwr_prev && !nwr_sync[SYNC_STAGES-1] && sel;
    assign rd_evt    = ncs_prev && !ncs_sync[SYNC_STAGES-1] && !nrd_sync[SYNC_STAGES-1] && sel;
    assign ncs_rise  = !ncs_prev && ncs_sync[SYNC_STAGES-1];
    assign cap_rise  = cap_sync[SYNC_STAGES-1] && !cap_prev;
    assign is_direct = reg_addr < NUM_A;

    assign ofs       = reg_addr - NUM_A;
    assign ofs_wide  = WW'(ofs) | WW'(BRAM_BASE);
    assign push_addr = ofs_wide[BRAM_ADDR_W-1:0];

    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = fifo_level == LW'(FIFO_DEPTH);
    assign empty      = fifo_level == '0;
    assign push_req   = wr_evt && !is_direct;
    assign pop        = (state == S_REQ) && Bram_WriteRegDone;
    assign push_ok    = push_req && (!full || pop);

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            for (int unsigned k = 0; k < NUM_DIRECT_REGS; k++) regs[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_DIRECT_REGS; k++) begin
                if (k == 0 && cap_rise)
                    regs[k] <= '0;
                else if (wr_evt && reg_addr == ADDR_BITS'(k))
                    regs[k] <= Cart_d_in;
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (push_ok) begin
            fifo_addr[wr_ptr[PW-1:0]] <= push_addr;
            fifo_data[wr_ptr[PW-1:0]] <= Cart_d_in;
        end
    end

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            Fifo_Overflow  <= 1'b0;
            state          <= S_IDLE;
            Bram_Req_Write <= 1'b0;
            Bram_Addr      <= '0;
            Bram_Data      <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (wr_evt && reg_addr == '0)
                Fifo_Overflow <= 1'b0;
            else if (push_req && !push_ok)
                Fifo_Overflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        state          <= S_REQ;
                        Bram_Req_Write <= 1'b1;
                        Bram_Addr      <= fifo_addr[rd_ptr[PW-1:0]];
                        Bram_Data      <= fifo_data[rd_ptr[PW-1:0]];
                    end
                end
                S_REQ: begin
                    if (Bram_WriteRegDone) begin
                        rd_ptr         <= rd_ptr + 1'b1;
                        state          <= S_IDLE;
                        Bram_Req_Write <= 1'b0;
                        Bram_Addr      <= '0;
                        Bram_Data      <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_value = '0;
        if (reg_addr == '0) rd_value = regs[0];
`ifdef GBCAM_REG_READBACK_EN
        for (int unsigned k = 1; k < NUM_DIRECT_REGS; k++)
            if (reg_addr == ADDR_BITS'(k)) rd_value = regs[k];
        if (reg_addr == '1) rd_value = {Fifo_Overflow, full, 6'(fifo_level)};
`endif
    end

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            Reg_OutputValid <= 1'b0;
            Reg_OutputData  <= '0;
        end else if (rd_evt) begin
            Reg_OutputValid <= 1'b1;
            Reg_OutputData  <= rd_value;
        end else if (ncs_rise) begin
            Reg_OutputValid <= 1'b0;
            Reg_OutputData  <= '0;
        end
    end

    always_comb begin
        Reg_Flat = '0;
        for (int unsigned k = 0; k < NUM_DIRECT_REGS; k++)
            Reg_Flat[8*k +: 8] = regs[k];
    end

    assign Cam_Capture = regs[0][0];
    assign Fifo_Level  = fifo_level;

endmodule
